// File: rtl/priority_encoder_rr_pkg.sv
// Shared definitions for the registered priority encoder: mode codes and
// width-generic helper functions used at elaboration and in logic.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Widest request vector f_onehot can describe; callers cast down to WIDTH.
  localparam int MAX_WIDTH = 256;

  typedef logic [MAX_WIDTH-1:0] onehot_t;

  function automatic int f_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic onehot_t f_onehot(input int unsigned index);
    onehot_t r;
    r        = '0;
    r[index] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle between the request sources, the encoder and the
// single consumer. The encoder uses the slave view.
interface priority_encoder_rr_if
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = f_clog2(WIDTH)
);
  logic             en;
  logic [WIDTH-1:0] req;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] onehot;
  logic             none;

  modport master (
    output en, req, out_ready,
    input  out_valid, idx, onehot, none
  );

  modport slave (
    input  en, req, out_ready,
    output out_valid, idx, onehot, none
  );
endinterface

// File: rtl/priority_encoder_rr_pick.sv
// Combinational highest-set-bit picker: reports whether any bit is set and
// the index of the most significant one.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = f_clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // NOTE: every output gets a default before the loop, otherwise an
  // all-zero vector leaves idx_o unassigned and a latch is inferred.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready output and a
// fixed (highest bit wins) or round-robin priority mode.
module priority_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = f_clog2(WIDTH),
  parameter int MODE  = MODE_FIXED
) (
  input  logic                 clk,
  input  logic                 rst,
  priority_encoder_rr_if.slave bus
);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic             none_q, none_d;

  logic             req_any;
  logic [IDX_W-1:0] all_idx;
  logic [IDX_W-1:0] grant;
  logic             slot_free;
  logic             cap;

  prio_pick #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pick_all (
    .vec_i   (bus.req),
    .found_o (req_any),
    .idx_o   (all_idx)
  );

  // A slot is free when nothing is held or the held grant leaves this cycle.
  assign slot_free = ~valid_q | bus.out_ready;
  assign cap       = bus.en & req_any & slot_free;
  assign none_d    = bus.en & ~req_any & slot_free;

  if (MODE == MODE_RR) begin : g_rr
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] mask;
    logic             msk_found;
    logic [IDX_W-1:0] msk_idx;

    always_comb begin
      mask = '0;
      for (int i = 0; i < WIDTH; i++) mask[i] = (IDX_W'(i) <= ptr_q);
    end

    prio_pick #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pick_msk (
      .vec_i   (bus.req & mask),
      .found_o (msk_found),
      .idx_o   (msk_idx)
    );

    assign grant = msk_found ? msk_idx : all_idx;

    // Pointer moves just below the winner, wrapping at WIDTH-1.
    always_comb begin
      ptr_d = ptr_q;
      if (cap) ptr_d = (grant == '0) ? IDX_W'(WIDTH - 1) : grant - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) ptr_q <= IDX_W'(WIDTH - 1);
      else     ptr_q <= ptr_d;
    end
  end else begin : g_fixed
    assign grant = all_idx;
  end

  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (cap) begin
      valid_d  = 1'b1;
      idx_d    = grant;
      onehot_d = WIDTH'(f_onehot(32'(grant)));
    end else if (valid_q && bus.out_ready) begin
      valid_d  = 1'b0;
      onehot_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous and has priority over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      none_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      none_q   <= none_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.idx       = idx_q;
  assign bus.onehot    = onehot_q;
  assign bus.none      = none_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Drives three encoder configurations (8/fixed, 8/round-robin, 5/round-robin)
// from one stimulus stream and compares each against a scan-based model.
module tb_priority_encoder_rr;
  import prio_enc_pkg::*;

  logic       clk;
  logic       rst;
  logic       en_r;
  logic       rdy_r;
  logic [7:0] req_r;

  int tests_run;
  int tests_failed;

  priority_encoder_rr_if #(.WIDTH(8)) if0 ();
  priority_encoder_rr_if #(.WIDTH(8)) if1 ();
  priority_encoder_rr_if #(.WIDTH(5)) if2 ();

  priority_encoder_rr #(.WIDTH(8), .MODE(MODE_FIXED)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  priority_encoder_rr #(.WIDTH(8), .MODE(MODE_RR))    dut1 (.clk(clk), .rst(rst), .bus(if1));
  priority_encoder_rr #(.WIDTH(5), .MODE(MODE_RR))    dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.en = en_r;  assign if0.req = req_r;      assign if0.out_ready = rdy_r;
  assign if1.en = en_r;  assign if1.req = req_r;      assign if1.out_ready = rdy_r;
  assign if2.en = en_r;  assign if2.req = req_r[4:0]; assign if2.out_ready = rdy_r;

  logic       d_v[3];
  logic [2:0] d_idx[3];
  logic [7:0] d_oh[3];
  logic       d_none[3];

  assign d_v[0] = if0.out_valid; assign d_idx[0] = if0.idx; assign d_oh[0] = if0.onehot;          assign d_none[0] = if0.none;
  assign d_v[1] = if1.out_valid; assign d_idx[1] = if1.idx; assign d_oh[1] = if1.onehot;          assign d_none[1] = if1.none;
  assign d_v[2] = if2.out_valid; assign d_idx[2] = if2.idx; assign d_oh[2] = {3'b000, if2.onehot}; assign d_none[2] = if2.none;

  // Reference model state, one slot per configuration.
  int         m_w[3]    = '{8, 8, 5};
  int         m_mode[3] = '{0, 1, 1};
  int         m_ptr[3];
  logic       m_v[3];
  int         m_idx[3];
  logic [7:0] m_oh[3];
  logic       m_none[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Walk priorities from the top (fixed) or from ptr (round-robin), wrapping.
  function automatic int model_grant(int w, int mode, int ptr, logic [7:0] r);
    int start;
    start = (mode == 0) ? w - 1 : ptr;
    for (int k = 0; k < w; k++) begin
      int i;
      i = (start - k + w) % w;
      if (r[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    for (int n = 0; n < 3; n++) begin
      logic [7:0] r;
      logic       free;
      int         g;
      if (rst) begin
        m_v[n] = 1'b0; m_idx[n] = 0; m_oh[n] = '0; m_none[n] = 1'b0;
        m_ptr[n] = m_w[n] - 1;
      end else begin
        free = !m_v[n] || rdy_r;
        g    = -1;
        if (en_r) begin
          r = req_r & 8'((1 << m_w[n]) - 1);
          g = model_grant(m_w[n], m_mode[n], m_ptr[n], r);
        end
        m_none[n] = en_r && (g < 0) && free;
        if (en_r && g >= 0 && free) begin
          m_v[n]   = 1'b1;
          m_idx[n] = g;
          m_oh[n]  = 8'(1 << g);
          if (m_mode[n] == 1) m_ptr[n] = (g == 0) ? m_w[n] - 1 : g - 1;
        end else if (m_v[n] && rdy_r) begin
          m_v[n]  = 1'b0;
          m_oh[n] = '0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int n = 0; n < 3; n++) begin
      check($sformatf("valid[%0d]", n),  32'(d_v[n]),    32'(m_v[n]));
      check($sformatf("idx[%0d]", n),    32'(d_idx[n]),  32'(m_idx[n]));
      check($sformatf("onehot[%0d]", n), 32'(d_oh[n]),   32'(m_oh[n]));
      check($sformatf("none[%0d]", n),   32'(d_none[n]), 32'(m_none[n]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] q, input logic y);
    rst = r; en_r = e; req_r = q; rdy_r = y;
  endtask

  int rr_seq[6] = '{7, 3, 0, 7, 3, 0};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int n = 0; n < 3; n++) begin
      m_v[n] = 1'b0; m_idx[n] = 0; m_oh[n] = '0; m_none[n] = 1'b0; m_ptr[n] = m_w[n] - 1;
    end

    // Reset held with all requests active, then first grant.
    drive(1'b1, 1'b1, 8'hFF, 1'b1);
    @(negedge clk);
    step(); step();
    drive(1'b0, 1'b1, 8'hFF, 1'b1);
    step();
    check("rst_first_idx", 32'(d_idx[0]), 32'd7);
    check("rst_first_rr",  32'(d_idx[1]), 32'd7);

    // Fixed sweep of single-bit requests, then empty, then disabled with X.
    for (int b = 7; b >= 0; b--) begin
      drive(1'b0, 1'b1, 8'(1 << b), 1'b1);
      step();
      check("sweep_idx", 32'(d_idx[0]), 32'(b));
    end
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    step();
    check("sweep_none",  32'(d_none[0]), 32'd1);
    check("sweep_valid", 32'(d_v[0]),    32'd0);
    drive(1'b0, 1'b0, 8'bxxxx_xxxx, 1'b1);
    step();
    check("en0_none", 32'(d_none[0]), 32'd0);

    // Round-robin fairness from a fresh pointer.
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 1'b1, 8'b1000_1001, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_fair", 32'(d_idx[1]), 32'(rr_seq[k]));
      check("fixed_same", 32'(d_idx[0]), 32'd7);
    end

    // Stall: grant held while req changes, then released.
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 1'b1, 8'h30, 1'b1);
    step();
    check("stall_cap", 32'(d_idx[1]), 32'd5);
    drive(1'b0, 1'b1, 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_hold", 32'(d_idx[1]), 32'd5);
    end
    drive(1'b0, 1'b1, 8'h01, 1'b1);
    step();
    check("stall_release", 32'(d_idx[1]), 32'd0);

    // Non-power-of-two width alternates between its two requests.
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    drive(1'b0, 1'b1, 8'h11, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step();
      check("w5_alt", 32'(d_idx[2]), (k % 2 == 0) ? 32'd4 : 32'd0);
    end

    // Reset during a stall discards the pending grant and rewinds ptr.
    drive(1'b0, 1'b1, 8'h09, 1'b1);
    step();
    drive(1'b0, 1'b1, 8'h09, 1'b0);
    step();
    drive(1'b1, 1'b1, 8'h89, 1'b0);
    step();
    check("rst_stall_valid", 32'(d_v[1]), 32'd0);
    drive(1'b0, 1'b1, 8'h89, 1'b1);
    step();
    check("rst_stall_ptr", 32'(d_idx[1]), 32'd7);

    // Randomised traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      int unsigned sel;
      logic [7:0]  q;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       q = 8'(1 << $urandom_range(0, 7));
        1:       q = 8'h00;
        default: q = 8'($urandom);
      endcase
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), q,
            ($urandom_range(0, 3) != 0));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready output handshake and a selectable fixed or round-robin priority mode. It generalises the 8-to-3 enabled priority encoder to any width. It adds a one-cycle output register with stall support and a rotating priority pointer. It sits between request sources (interrupt lines, FIFO non-empty flags) and a single consumer that services one index at a time.

## Interface
- `WIDTH`, default 8: number of request lines; must be ≥ 2.
- `IDX_W`, default `$clog2(WIDTH)`: index width; derived, not overridden.
- `MODE`, default 0: 0 = fixed priority, highest bit wins; 1 = round-robin.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `en` input, 1 bit: capture enable; when 0, `req` is ignored, including X.
- `req` input, `WIDTH` bits: request vector; bit k requests index k.
- `out_ready` input, 1 bit: consumer accepts `idx` this cycle.
- `out_valid` output, 1 bit: `idx`/`onehot` hold a valid grant.
- `idx` output, `IDX_W` bits: encoded index of the granted request.
- `onehot` output, `WIDTH` bits: one-hot form of `idx`; all zero when `out_valid` = 0.
- `none` output, 1 bit: registered; 1 for one cycle after a capture attempt with `en` = 1 and `req` = 0.

## Operation
- **Capture condition:** `cap = en & (req != 0) & (!out_valid | out_ready)`.
- **On `cap`:**
  - `idx` ← grant.
  - `onehot` ← 1 << grant.
  - `out_valid` ← 1.
  - In `MODE` = 1, the pointer updates.
- **Handshake completes without new capture** (`out_valid & out_ready & !cap`): `out_valid` ← 0, `onehot` ← 0; `idx` holds its last value.
- **Stall** (`out_valid & !out_ready`): `idx`, `onehot`, `out_valid` and `ptr` all hold; `req` is not sampled; dropped requests are the source's responsibility.
- **`none`:** ← `en & (req == 0) & (!out_valid | out_ready)`; otherwise 0.
- **Fixed mode:** grant = highest set bit of `req`. Example: `req` = 8'b0010_0110 → 5.
- **Round-robin mode:**
  - `ptr` (`IDX_W` bits) names the highest-priority bit. Priority descends `ptr`, `ptr`−1, …, 0, then wraps to `WIDTH`−1, …, `ptr`+1.
  - After granting g: `ptr` ← g−1, or `WIDTH`−1 when g = 0.
  - Implementation: mask = bits ≤ `ptr`. If `req & mask` ≠ 0, grant = its highest set bit; otherwise grant = highest set bit of `req`.
- **Non-power-of-2 `WIDTH`:** `idx` never exceeds `WIDTH`−1; `ptr` wraps at `WIDTH`−1, not 2^`IDX_W`−1.

## Timing
- **Latency:** 1 cycle, from `req` sampled at edge n to `idx`/`out_valid` visible after edge n.
- **Throughput:** one grant per cycle while `out_ready` = 1 (back-to-back capture on the same edge that completes the handshake).
- **Reset values** (`rst` high at an edge):
  - `out_valid` = 0, `idx` = 0, `onehot` = 0, `none` = 0.
  - `ptr` = `WIDTH`−1, so the first RR grant equals the fixed-mode grant.
- **Reset mid-operation:** a pending unaccepted grant is discarded; `rst` overrides `cap` on the same edge.
- **`en` falling while `out_valid` = 1:** the held grant is still delivered; no new capture.
- **Single request line:** both modes grant that line every cycle; in RR, `ptr` still advances.

## Structure
- Shared package `prio_enc_pkg` holds:
  - `MODE_FIXED` = 0, `MODE_RR` = 1.
  - A width-generic `f_clog2` function.
  - A `f_onehot` function.
- Sub-module `prio_pick` (combinational, parameter `WIDTH`): vector in, `{found, index}` out, highest set bit wins.
  - Instantiated twice in RR mode: masked and unmasked vectors.
  - Instantiated once in fixed mode.
- Output register, `ptr` register and handshake logic live in the top; `ptr` logic is generated only when `MODE` = 1.

## Test plan
- **Reset/idle:** assert `rst` 2 cycles with `req` = 8'hFF, `en` = 1 → `out_valid` = 0, `idx` = 0, `onehot` = 0 throughout reset; first grant `idx` = 7 one cycle after release.
- **Fixed sweep** (`WIDTH` = 8, `MODE` = 0, `out_ready` = 1): `req` = 128, 64, 32 … 1, one per cycle → `idx` = 7, 6, … 0 one cycle later each; then `req` = 0 → `none` = 1, `out_valid` = 0; then `en` = 0 with `req` = 8'bx → `out_valid` = 0, `none` = 0.
- **Round-robin fairness** (`MODE` = 1): `req` held 8'b1000_1001, `out_ready` = 1 → `idx` sequence 7, 3, 0, 7, 3, 0; fixed mode with the same stimulus → 7 every cycle.
- **Stall:** capture `req` = 8'h30 → `idx` = 5; hold `out_ready` = 0 for 3 cycles while `req` changes to 8'h01 → `idx` stays 5, `out_valid` = 1, `ptr` unchanged; raise `out_ready` → next cycle `idx` = 0.
- **Non-power-of-2** (`WIDTH` = 5, `MODE` = 1): `req` = 5'b10001 held → `idx` alternates 4, 0; `ptr` never exceeds 4.
- **Reset mid-stall:** `out_valid` = 1, `out_ready` = 0, pulse `rst` → `out_valid` = 0 next cycle, `ptr` = `WIDTH`−1, pending grant lost.
